// File: rtl/wash_pkg.sv
// Shared definitions for the washing-machine program controller:
// state encodings, display codes, LED bit positions and phase-mask helpers.
package wash_pkg;

    typedef enum logic [2:0] {
        ST_SHUTDOWN = 3'd0,
        ST_BEGIN    = 3'd1,
        ST_SET      = 3'd2,
        ST_RUN      = 3'd3,
        ST_ERROR    = 3'd4,
        ST_PAUSE    = 3'd5,
        ST_FINISH   = 3'd6
    } state_t;

    localparam logic [5:0] DIG_EMPTY = 6'd55;
    localparam logic [5:0] DIG_FULL  = 6'd56;
    localparam logic [5:0] DIG_PAUSE = 6'd57;

    localparam int LED_SET        = 9;
    localparam int LED_POWER      = 8;
    localparam int LED_WASH_IN    = 7;
    localparam int LED_WASH       = 6;
    localparam int LED_RINSE_OUT  = 5;
    localparam int LED_RINSE_SPIN = 4;
    localparam int LED_RINSE_IN   = 3;
    localparam int LED_RINSE      = 2;
    localparam int LED_DRY_OUT    = 1;
    localparam int LED_DRY_SPIN   = 0;

    localparam logic [2:0] MODE_RESET = 3'd7;

    // Sub-phase bits [7:0] enabled by the 3-bit program mask.
    function automatic logic [7:0] phase_mask(input logic [2:0] mode);
        phase_mask = {{2{mode[2]}}, {4{mode[1]}}, {2{mode[0]}}};
    endfunction

    // Highest enabled sub-phase; sub-phases run from bit 7 down to bit 0.
    function automatic logic [2:0] first_phase(input logic [7:0] mask);
        first_phase = 3'd0;
        for (int j = 0; j < 8; j++) begin
            if (mask[3'(j)]) first_phase = 3'(j);
        end
    endfunction

    // {found, index} of the next enabled sub-phase below cur.
    function automatic logic [3:0] next_phase(input logic [7:0] mask, input logic [2:0] cur);
        next_phase = 4'd0;
        for (int j = 0; j < 8; j++) begin
            if ((3'(j) < cur) && mask[3'(j)]) next_phase = {1'b1, 3'(j)};
        end
    endfunction

endpackage

// File: rtl/wash_phase_timer.sv
// Loadable down-counter advanced by a tick enable, frozen by hold.
// done is a same-cycle pulse on the tick that takes the count from 1 to 0.
module wash_phase_timer #(
    parameter int W = 7
) (
    input  logic         cp,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         hold,
    output logic         done
);

    logic [W-1:0] count;

    assign done = en && !hold && (count == W'(1));

    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && !hold && (count != '0)) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/wash_sequencer.sv
// Washing-machine program controller: machine FSM plus wash/rinse/dry sequencing
// on a 1 Hz tick; all outputs registered from the next-state values.
module wash_sequencer
    import wash_pkg::*;
#(
    parameter int T_IN         = 2,
    parameter int T_WASH       = 6,
    parameter int T_OUT        = 2,
    parameter int T_SPIN       = 2,
    parameter int T_RINSE      = 4,
    parameter int BEGIN_TICKS  = 2,
    parameter int FINISH_TICKS = 3
) (
    input  logic       cp,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       power,
    input  logic       start_pause,
    input  logic       mode_next,
    input  logic       lid_open,
    output logic [2:0] state,
    output logic [9:0] data,
    output logic [5:0] inLeft,
    output logic [5:0] inMiddle,
    output logic [5:0] inRight
);

    localparam logic [6:0] BEGIN_LAST  = 7'(BEGIN_TICKS - 1);
    localparam logic [6:0] FINISH_LAST = 7'(FINISH_TICKS - 1);

    function automatic logic [6:0] phase_len(input logic [2:0] idx);
        case (idx)
            3'd7, 3'd3: phase_len = 7'(T_IN);
            3'd6:       phase_len = 7'(T_WASH);
            3'd5, 3'd1: phase_len = 7'(T_OUT);
            3'd4, 3'd0: phase_len = 7'(T_SPIN);
            default:    phase_len = 7'(T_RINSE);
        endcase
    endfunction

    function automatic logic [6:0] total_len(input logic [2:0] m);
        total_len = '0;
        if (m[2]) total_len = total_len + 7'(T_IN + T_WASH);
        if (m[1]) total_len = total_len + 7'(T_OUT + T_SPIN + T_IN + T_RINSE);
        if (m[0]) total_len = total_len + 7'(T_OUT + T_SPIN);
    endfunction

    state_t     st, st_n;
    logic [2:0] mode, mode_n;
    logic [6:0] rem, rem_n;
    logic [6:0] cnt, cnt_n;
    logic [2:0] ph, ph_n;
    logic [3:0] nxt;

    logic       t_load;
    logic [6:0] t_val;
    logic       t_hold;
    logic       t_done;

    // The sub-phase counter only moves on a tick that the run state actually consumes.
    assign t_hold = (st != ST_RUN) || power || lid_open || start_pause;

    wash_phase_timer #(.W(7)) u_timer (
        .cp       (cp),
        .rst_n    (rst_n),
        .load     (t_load),
        .load_val (t_val),
        .en       (tick),
        .hold     (t_hold),
        .done     (t_done)
    );

    always_comb begin
        st_n   = st;
        mode_n = mode;
        rem_n  = rem;
        cnt_n  = cnt;
        ph_n   = ph;
        nxt    = 4'd0;
        t_load = 1'b0;
        t_val  = '0;
        if (power) begin
            if (st == ST_SHUTDOWN) begin
                st_n  = ST_BEGIN;
                cnt_n = '0;
            end else begin
                st_n   = ST_SHUTDOWN;
                rem_n  = '0;
                cnt_n  = '0;
                ph_n   = '0;
                t_load = 1'b1;
            end
        end else begin
            case (st)
                ST_BEGIN: begin
                    if (tick) begin
                        if (cnt == BEGIN_LAST) begin
                            st_n  = ST_SET;
                            cnt_n = '0;
                        end else begin
                            cnt_n = cnt + 7'd1;
                        end
                    end
                end
                ST_SET: begin
                    if (start_pause) begin
                        st_n   = ST_RUN;
                        rem_n  = total_len(mode);
                        ph_n   = first_phase(phase_mask(mode));
                        t_load = 1'b1;
                        t_val  = phase_len(ph_n);
                    end else if (mode_next) begin
                        mode_n = (mode == 3'd7) ? 3'd1 : mode + 3'd1;
                    end
                end
                ST_RUN: begin
                    if (lid_open) begin
                        st_n = ST_ERROR;
                    end else if (start_pause) begin
                        st_n = ST_PAUSE;
                    end else if (tick) begin
                        rem_n = rem - 7'd1;
                        if (t_done) begin
                            nxt = next_phase(phase_mask(mode), ph);
                            if (nxt[3]) begin
                                ph_n   = nxt[2:0];
                                t_load = 1'b1;
                                t_val  = phase_len(nxt[2:0]);
                            end else begin
                                st_n  = ST_FINISH;
                                cnt_n = '0;
                            end
                        end
                    end
                end
                ST_PAUSE: begin
                    if (lid_open) begin
                        st_n = ST_ERROR;
                    end else if (start_pause) begin
                        st_n = ST_RUN;
                    end
                end
                ST_ERROR: begin
                    if (!lid_open && start_pause) st_n = ST_RUN;
                end
                ST_FINISH: begin
                    if (tick) begin
                        if (cnt == FINISH_LAST) begin
                            st_n  = ST_SET;
                            cnt_n = '0;
                        end else begin
                            cnt_n = cnt + 7'd1;
                        end
                    end
                end
                default: st_n = st;
            endcase
        end
    end

    logic [6:0] disp;
    logic [9:0] led_n;
    logic [5:0] dl_n, dm_n, dr_n;

    always_comb begin
        disp  = (st_n == ST_SET) ? total_len(mode_n) : rem_n;
        led_n = '0;
        led_n[LED_POWER] = (st_n != ST_SHUTDOWN);
        led_n[LED_SET]   = (st_n == ST_SET);
        if (st_n == ST_SET) begin
            led_n[7:0] = phase_mask(mode_n);
        end else if ((st_n == ST_RUN) || (st_n == ST_PAUSE)) begin
            led_n[7:0] = 8'd1 << ph_n;
        end
        case (st_n)
            ST_SHUTDOWN: begin
                dl_n = DIG_EMPTY;
                dm_n = DIG_EMPTY;
                dr_n = DIG_EMPTY;
            end
            ST_BEGIN, ST_FINISH: begin
                dl_n = DIG_FULL;
                dm_n = DIG_FULL;
                dr_n = DIG_FULL;
            end
            default: begin
                dl_n = 6'(disp / 7'd10);
                dm_n = {3'd0, mode_n};
                dr_n = 6'(disp % 7'd10);
            end
        endcase
    end

    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            st       <= ST_SHUTDOWN;
            mode     <= MODE_RESET;
            rem      <= '0;
            cnt      <= '0;
            ph       <= '0;
            data     <= '0;
            inLeft   <= DIG_EMPTY;
            inMiddle <= DIG_EMPTY;
            inRight  <= DIG_EMPTY;
        end else begin
            st       <= st_n;
            mode     <= mode_n;
            rem      <= rem_n;
            cnt      <= cnt_n;
            ph       <= ph_n;
            data     <= led_n;
            inLeft   <= dl_n;
            inMiddle <= dm_n;
            inRight  <= dr_n;
        end
    end

    assign state = st;

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed, table-driven bench for wash_sequencer with default timing parameters.
module tb_wash_sequencer;

    logic       cp = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0, power = 1'b0, start_pause = 1'b0, mode_next = 1'b0, lid_open = 1'b0;
    logic [2:0] state;
    logic [9:0] data;
    logic [5:0] inLeft, inMiddle, inRight;

    int checks = 0;
    int failures = 0;

    always #5 cp = ~cp;

    wash_sequencer dut (
        .cp(cp), .rst_n(rst_n), .tick(tick), .power(power), .start_pause(start_pause),
        .mode_next(mode_next), .lid_open(lid_open), .state(state), .data(data),
        .inLeft(inLeft), .inMiddle(inMiddle), .inRight(inRight)
    );

    typedef struct packed {
        logic       pw, sp, mn, lid, tk;
        logic [2:0] st;
        logic [9:0] dat;
        logic [5:0] l, m, r;
    } vec_t;

    vec_t vecs[11];
    int   dur[8] = '{2, 6, 2, 2, 2, 4, 2, 2};

    task automatic chk(input string name, input logic [2:0] st, input logic [9:0] dat,
                       input logic [5:0] l, input logic [5:0] m, input logic [5:0] r);
        checks++;
        if (state !== st || data !== dat || inLeft !== l || inMiddle !== m || inRight !== r) begin
            failures++;
            $display("FAIL %s: got state=%0d data=%b digits=%0d,%0d,%0d expected state=%0d data=%b digits=%0d,%0d,%0d",
                     name, state, data, inLeft, inMiddle, inRight, st, dat, l, m, r);
        end
    endtask

    // One cycle of event inputs, then idle; outputs are sampled on the following falling edge.
    task automatic step(input logic pw, input logic sp, input logic mn, input logic lid, input logic tk);
        @(negedge cp);
        power = pw; start_pause = sp; mode_next = mn; lid_open = lid; tick = tk;
        @(negedge cp);
        power = 1'b0; start_pause = 1'b0; mode_next = 1'b0; tick = 1'b0;
    endtask

    // Expected one-hot LED bit for a mode-7 run after k consumed ticks.
    function automatic int run_bit(input int k);
        int cum = 0;
        run_bit = 0;
        for (int p = 0; p < 8; p++) begin
            cum += dur[p];
            if (cum > k) return 7 - p;
        end
    endfunction

    initial begin
        int rem;
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 10'b01_0000_0000, 6'd56, 6'd56, 6'd56};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 10'b01_0000_0000, 6'd56, 6'd56, 6'd56};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 10'b11_1111_1111, 6'd2, 6'd7, 6'd2};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 10'b11_0000_0011, 6'd0, 6'd1, 6'd4};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 10'b11_0011_1100, 6'd1, 6'd2, 6'd0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 10'b11_0011_1111, 6'd1, 6'd3, 6'd4};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 10'b11_1100_0000, 6'd0, 6'd4, 6'd8};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 10'b11_1100_0000, 6'd0, 6'd4, 6'd8};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 10'b11_1100_0011, 6'd1, 6'd5, 6'd2};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 10'b11_1111_1100, 6'd1, 6'd6, 6'd8};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 10'b11_1111_1111, 6'd2, 6'd7, 6'd2};

        repeat (3) @(negedge cp);
        chk("reset_values", 3'd0, 10'd0, 6'd55, 6'd55, 6'd55);
        rst_n = 1'b1;
        @(negedge cp);
        chk("after_reset_idle", 3'd0, 10'd0, 6'd55, 6'd55, 6'd55);

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].pw, vecs[i].sp, vecs[i].mn, vecs[i].lid, vecs[i].tk);
            chk($sformatf("vec%0d", i), vecs[i].st, vecs[i].dat, vecs[i].l, vecs[i].m, vecs[i].r);
        end

        // Full mode-7 program; the tick coincident with start must be ignored.
        step(0, 1, 0, 0, 1);
        chk("run_entry", 3'd3, 10'b01_1000_0000, 6'd2, 6'd7, 6'd2);
        for (int k = 1; k <= 22; k++) begin
            step(0, 0, 0, 0, 1);
            rem = 22 - k;
            if (k < 22)
                chk($sformatf("run_tick%0d", k), 3'd3, 10'h100 | (10'd1 << run_bit(k)),
                    6'(rem / 10), 6'd7, 6'(rem % 10));
            else
                chk("run_to_finish", 3'd6, 10'b01_0000_0000, 6'd56, 6'd56, 6'd56);
        end
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("finish_hold", 3'd6, 10'b01_0000_0000, 6'd56, 6'd56, 6'd56);
        step(0, 0, 0, 0, 1);
        chk("finish_to_set", 3'd2, 10'b11_1111_1111, 6'd2, 6'd7, 6'd2);

        // Pause holds everything across ticks.
        step(0, 1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 1);
        chk("run_3ticks", 3'd3, 10'b01_0100_0000, 6'd1, 6'd7, 6'd9);
        step(0, 1, 0, 0, 0);
        chk("pause_enter", 3'd5, 10'b01_0100_0000, 6'd1, 6'd7, 6'd9);
        repeat (5) step(0, 0, 0, 0, 1);
        chk("pause_hold", 3'd5, 10'b01_0100_0000, 6'd1, 6'd7, 6'd9);
        step(0, 1, 0, 0, 0);
        chk("pause_resume", 3'd3, 10'b01_0100_0000, 6'd1, 6'd7, 6'd9);
        step(0, 0, 0, 0, 1);
        chk("resume_tick", 3'd3, 10'b01_0100_0000, 6'd1, 6'd7, 6'd8);

        // Lid open: error, start ignored while open, resume at the same count.
        step(0, 0, 0, 1, 1);
        chk("lid_error", 3'd4, 10'b01_0000_0000, 6'd1, 6'd7, 6'd8);
        step(0, 1, 0, 1, 0);
        chk("error_start_lid_open", 3'd4, 10'b01_0000_0000, 6'd1, 6'd7, 6'd8);
        step(0, 0, 0, 0, 1);
        chk("error_tick_ignored", 3'd4, 10'b01_0000_0000, 6'd1, 6'd7, 6'd8);
        step(0, 1, 0, 0, 0);
        chk("error_resume", 3'd3, 10'b01_0100_0000, 6'd1, 6'd7, 6'd8);
        step(0, 0, 0, 0, 1);
        chk("error_resume_tick", 3'd3, 10'b01_0100_0000, 6'd1, 6'd7, 6'd7);

        step(1, 1, 0, 0, 0);
        chk("power_beats_start", 3'd0, 10'd0, 6'd55, 6'd55, 6'd55);

        // Mode 4 run, then asynchronous reset mid-run.
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        repeat (4) step(0, 0, 1, 0, 0);
        chk("mode4_preview", 3'd2, 10'b11_1100_0000, 6'd0, 6'd4, 6'd8);
        step(0, 1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 1);
        chk("mode4_run", 3'd3, 10'b01_0100_0000, 6'd0, 6'd4, 6'd5);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", 3'd0, 10'd0, 6'd55, 6'd55, 6'd55);
        @(negedge cp);
        rst_n = 1'b1;
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("mode_restored", 3'd2, 10'b11_1111_1111, 6'd2, 6'd7, 6'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
